// File: rtl/world_clock_multi.sv
// Multi-zone world clock: binary base time, per-zone minute offsets and a
// registered BCD display of the selected zone against home or base seconds.

module wcm_zone_ofs #(
  parameter int OFS_STEP = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_hr,
  input  logic        inc_qtr,
  output logic [10:0] ofs
);
  logic signed [11:0] sum;

  always_comb begin
    sum = $signed({ofs[10], ofs}) + (inc_hr ? 12'sd60 : $signed(12'(OFS_STEP)));
  end

  // Offsets only ever grow, so stepping past +840 lands on the western limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ofs <= '0;
    else if (inc_hr || inc_qtr) ofs <= (sum > 12'sd840) ? 11'h530 : sum[10:0];
  end
endmodule

module world_clock_multi #(
  parameter int NUM_ZONES    = 4,
  parameter int OFS_STEP_MIN = 15,
  parameter int ZW           = (NUM_ZONES > 2) ? $clog2(NUM_ZONES) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          set_en,
  input  logic [4:0]    set_hh,
  input  logic [5:0]    set_mm,
  input  logic          btn_zone,
  input  logic          btn_hr,
  input  logic          btn_qtr,
  input  logic          btn_mode,
  output logic [ZW-1:0] zone_sel,
  output logic          mode,
  output logic [31:0]   disp_bcd,
  output logic [1:0]    day_adj,
  output logic          day_wrap
);
  logic [5:0]    sec, mn;
  logic [4:0]    hr;
  logic [ZW-1:0] zsel_q;
  logic          mode_q, wrap_q, armed;
  logic [3:0]    btn, btn_d, edg;
  logic          set_ok, at_end;
  logic [NUM_ZONES-1:0][10:0] ofs;

  logic [10:0]        base_m;
  logic signed [12:0] sel_pre, home_pre;
  logic [15:0]        sel_hhmm;
  logic [31:0]        disp_nxt;
  logic [1:0]         adj_nxt;

  function automatic logic [7:0] bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic signed [12:0] loc_pre(input logic [10:0] bm, input logic [10:0] o);
    return $signed({2'b00, bm}) + $signed({{2{o[10]}}, o});
  endfunction

  function automatic logic [10:0] loc_red(input logic signed [12:0] p);
    if (p < 13'sd0)         return 11'(p + 13'sd1440);
    else if (p >= 13'sd1440) return 11'(p - 13'sd1440);
    else                    return 11'(p);
  endfunction

  function automatic logic [15:0] hhmm(input logic [10:0] m);
    return {bcd2(7'(m / 11'd60)), bcd2(7'(m % 11'd60))};
  endfunction

  // armed stays low for the first edge after reset so a held button is not seen as a rise.
  assign btn    = {btn_mode, btn_qtr, btn_hr, btn_zone};
  assign edg    = btn & ~btn_d & {4{armed}};
  assign set_ok = set_en && (set_hh <= 5'd23) && (set_mm <= 6'd59);
  assign at_end = (hr == 5'd23) && (mn == 6'd59) && (sec == 6'd59);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec    <= '0;
      mn     <= '0;
      hr     <= '0;
      wrap_q <= 1'b0;
    end else if (set_ok) begin
      sec    <= '0;
      mn     <= set_mm;
      hr     <= set_hh;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= tick && at_end;
      if (tick) begin
        sec <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
        if (sec == 6'd59) begin
          mn <= (mn == 6'd59) ? 6'd0 : mn + 6'd1;
          if (mn == 6'd59) hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_d  <= '0;
      armed  <= 1'b0;
      zsel_q <= '0;
      mode_q <= 1'b0;
    end else begin
      btn_d <= btn;
      armed <= 1'b1;
      if (edg[0]) zsel_q <= (zsel_q == ZW'(NUM_ZONES - 1)) ? '0 : zsel_q + 1'b1;
      if (edg[3]) mode_q <= ~mode_q;
    end
  end

  // Offset steps use the pre-increment zone_sel; hr wins over qtr.
  for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
    wcm_zone_ofs #(.OFS_STEP(OFS_STEP_MIN)) u_ofs (
      .clk    (clk),
      .reset  (reset),
      .inc_hr (edg[1] && (zsel_q == ZW'(z))),
      .inc_qtr(edg[2] && !edg[1] && (zsel_q == ZW'(z))),
      .ofs    (ofs[z])
    );
  end

  always_comb begin
    base_m   = 11'(hr) * 11'd60 + 11'(mn);
    sel_pre  = loc_pre(base_m, ofs[zsel_q]);
    home_pre = loc_pre(base_m, ofs[0]);
    sel_hhmm = hhmm(loc_red(sel_pre));
    disp_nxt = mode_q ? {sel_hhmm, bcd2(7'(sec)), bcd2(7'(zsel_q))}
                      : {sel_hhmm, hhmm(loc_red(home_pre))};
    adj_nxt  = (sel_pre < 13'sd0) ? 2'b11 : (sel_pre >= 13'sd1440) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zone_sel <= '0;
      mode     <= 1'b0;
      disp_bcd <= '0;
      day_adj  <= 2'b00;
      day_wrap <= 1'b0;
    end else begin
      zone_sel <= zsel_q;
      mode     <= mode_q;
      disp_bcd <= disp_nxt;
      day_adj  <= adj_nxt;
      day_wrap <= wrap_q;
    end
  end
endmodule

// File: tb/tb_world_clock_multi.sv
// Scoreboard bench for world_clock_multi: a seconds-of-day/minute-offset model
// predicts each output cycle; a monitor pops and compares on the falling edge.

module tb_world_clock_multi;
  localparam int NZ   = 8;
  localparam int STEP = 15;

  logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, set_en = 1'b0;
  logic [4:0] set_hh = '0;
  logic [5:0] set_mm = '0;
  logic [3:0] btn = '0;   // {mode, qtr, hr, zone}
  logic [2:0] zone_sel;
  logic       mode, day_wrap;
  logic [31:0] disp_bcd;
  logic [1:0] day_adj;

  typedef struct packed {
    logic [2:0]  zone;
    logic        mode;
    logic [31:0] disp;
    logic [1:0]  adj;
    logic        wrap;
  } out_t;

  out_t exp_q[$];
  int   checks = 0, errors = 0;

  int  m_sod;
  int  m_ofs[NZ];
  int  m_zone;
  bit  m_mode, m_wrap, m_armed;
  bit  [3:0] m_prev, m_e;

  world_clock_multi #(.NUM_ZONES(NZ), .OFS_STEP_MIN(STEP)) dut (
    .clk(clk), .reset(reset), .tick(tick), .set_en(set_en),
    .set_hh(set_hh), .set_mm(set_mm),
    .btn_zone(btn[0]), .btn_hr(btn[1]), .btn_qtr(btn[2]), .btn_mode(btn[3]),
    .zone_sel(zone_sel), .mode(mode), .disp_bcd(disp_bcd),
    .day_adj(day_adj), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd2(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int wrap_day(input int pre);
    if (pre < 0) return pre + 1440;
    if (pre >= 1440) return pre - 1440;
    return pre;
  endfunction

  function automatic out_t model_out();
    out_t o;
    int pre, m, m0;
    pre = m_sod / 60 + m_ofs[m_zone];
    m   = wrap_day(pre);
    m0  = wrap_day(m_sod / 60 + m_ofs[0]);
    o.zone = 3'(m_zone);
    o.mode = m_mode;
    o.wrap = m_wrap;
    o.adj  = (pre < 0) ? 2'b11 : (pre >= 1440) ? 2'b01 : 2'b00;
    o.disp[31:16] = {bcd2(m / 60), bcd2(m % 60)};
    if (m_mode) o.disp[15:0] = {bcd2(m_sod % 60), bcd2(m_zone)};
    else        o.disp[15:0] = {bcd2(m0 / 60), bcd2(m0 % 60)};
    return o;
  endfunction

  // Reference model: outputs seen after an edge reflect the state before it.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_sod = 0; m_zone = 0; m_mode = 0; m_wrap = 0; m_armed = 0; m_prev = '0;
      foreach (m_ofs[i]) m_ofs[i] = 0;
      exp_q.delete();
    end else begin
      exp_q.push_back(model_out());
      m_wrap = 0;
      if (set_en && set_hh <= 23 && set_mm <= 59) m_sod = set_hh * 3600 + set_mm * 60;
      else if (tick) begin
        m_wrap = (m_sod == 86399);
        m_sod  = (m_sod + 1) % 86400;
      end
      m_e = m_armed ? (btn & ~m_prev) : 4'b0;
      if (m_e[1] || m_e[2]) begin
        m_ofs[m_zone] += m_e[1] ? 60 : STEP;
        if (m_ofs[m_zone] > 840) m_ofs[m_zone] = -720;
      end
      if (m_e[0]) m_zone = (m_zone + 1) % NZ;
      if (m_e[3]) m_mode = !m_mode;
      m_prev  = btn;
      m_armed = 1;
    end
  end

  task automatic chk(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got zone=%0d mode=%b disp=%h adj=%b wrap=%b, expected zone=%0d mode=%b disp=%h adj=%b wrap=%b",
               name, $time, got.zone, got.mode, got.disp, got.adj, got.wrap,
               exp.zone, exp.mode, exp.disp, exp.adj, exp.wrap);
    end
  endtask

  // Monitor: away from the active edge, compare against reset values or the scoreboard.
  initial forever begin
    @(negedge clk);
    if (reset) chk("reset_outputs", {zone_sel, mode, disp_bcd, day_adj, day_wrap}, '0);
    else if (exp_q.size() > 0)
      chk("outputs", {zone_sel, mode, disp_bcd, day_adj, day_wrap}, exp_q.pop_front());
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1; step();
    btn[b] = 1'b0; step();
  endtask

  task automatic set_time(input int h, input int m);
    set_hh = 5'(h); set_mm = 6'(m); set_en = 1'b1; step();
    set_en = 1'b0; step();
  endtask

  // Reset asserted mid-cycle so the monitor sees it before any clock edge.
  task automatic mid_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    step(2);
    reset = 1'b0;
    step();
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    step();

    // Midnight rollover from 23:59:00 after 60 ticks.
    set_time(23, 59);
    repeat (60) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
    step(3);

    // Zone 1: +2h then 6 quarter steps at base 01:30 -> 05:00.
    set_time(1, 30);
    press(0);
    repeat (2) press(1);
    repeat (6) press(2);
    step(3);

    // Drive zone 1 offset to +840, then one hour step wraps it to -720.
    repeat (42) press(2);
    press(1);
    set_time(0, 10);
    step(3);

    // Coincident hr+qtr on zone 2, then held high.
    press(0);
    btn[1] = 1'b1; btn[2] = 1'b1;
    step(10);
    btn[1] = 1'b0; btn[2] = 1'b0;
    step(2);

    // Rejected loads while ticking.
    set_time(5, 0);
    set_hh = 5'd24; set_mm = 6'd0; set_en = 1'b1; tick = 1'b1; step();
    set_en = 1'b0; tick = 1'b0; step();
    set_hh = 5'd5; set_mm = 6'd60; set_en = 1'b1; tick = 1'b1; step();
    set_en = 1'b0; tick = 1'b0; step(3);

    // Mode 1 zone cycling over all eight zones, then reset with buttons held.
    mid_reset();
    press(3);
    repeat (7) press(0);
    step(2);
    press(0);
    step(2);
    btn = 4'hF;
    mid_reset();
    step(3);
    btn = 4'h0;
    step(2);

    // Randomized traffic.
    repeat (3000) begin
      tick   = ($urandom_range(3) == 0);
      set_en = ($urandom_range(150) == 0);
      set_hh = 5'($urandom_range(31));
      set_mm = 6'($urandom_range(63));
      if (set_en && $urandom_range(1) == 0) begin
        set_hh = 5'd23; set_mm = 6'd59;
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) btn[b] = ~btn[b];
      if ($urandom_range(400) == 0) begin
        reset = 1'b1; step();
        reset = 1'b0;
      end
      step();
    end
    tick = 1'b0; set_en = 1'b0; btn = '0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/world_clock_multi.md
WORLD_CLOCK_MULTI -- requirements
Module: world_clock_multi

Interface
REQ-001 SHALL have parameter NUM_ZONES, default 4, number of time zones (legal range 2..8).
REQ-002 SHALL have parameter OFS_STEP_MIN, default 15, minute step applied by btn_qtr (legal values 15 or 30).
REQ-003 SHALL derive ZW = max(1, clog2(NUM_ZONES)) as the zone-index width.
REQ-004 Ports, in order:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  1 Hz enable, one clk cycle wide.
- set_en  in  1  load base time this cycle.
- set_hh  in  5  binary hours to load.
- set_mm  in  6  binary minutes to load.
- btn_zone  in  1  raw level; a rising edge selects the next zone.
- btn_hr  in  1  raw level; a rising edge adds +60 min to the selected zone's offset.
- btn_qtr  in  1  raw level; a rising edge adds +OFS_STEP_MIN min to the selected zone's offset.
- btn_mode  in  1  raw level; a rising edge toggles the display mode.
- zone_sel  out  ZW  currently selected zone.
- mode  out  1  display mode.
- disp_bcd  out  32  eight BCD digits; [31:28] is the leftmost digit.
- day_adj  out  2  selected zone's day relative to base: 2'b11 = -1, 2'b00 = 0, 2'b01 = +1.
- day_wrap  out  1  one-cycle pulse when base time rolls from 23:59:59 to 00:00:00.

Function
REQ-005 SHALL keep base time as binary registers sec (0..59), min (0..59) and hr (0..23).
REQ-006 On tick: sec increments; at 59 it wraps to 0 and carries into min; min 59 wraps and carries into hr; hr 23 wraps to 0.
REQ-007 SHALL assert day_wrap for exactly the cycle after the tick that moves the base time from 23:59:59 to 00:00:00.
REQ-008 On set_en with set_hh <= 23 and set_mm <= 59: load hr/min from set_hh/set_mm, set sec = 0, and ignore tick in the same cycle.
REQ-009 On set_en with set_hh > 23 or set_mm > 59: ignore the load entirely; tick is still processed normally.
REQ-010 SHALL hold one signed 11-bit offset per zone, in minutes, with legal range -720..+840.
REQ-011 Zone 0 is the home zone.
REQ-012 SHALL edge-detect each btn_* input against a one-cycle delayed copy; an edge acts in the cycle the rise is seen; holding a button produces no repeat action.
REQ-013 Offset step: new = old + step; if the result is > +840, new = -720 exactly.
REQ-014 If btn_hr and btn_qtr edges coincide, apply only btn_hr.
REQ-015 btn_zone edge: zone_sel = zone_sel + 1, wrapping from NUM_ZONES-1 to 0.
REQ-016 If a zone edge coincides with an offset edge, the offset change applies to the pre-increment zone_sel.
REQ-017 Local minute-of-day for zone z: L = hr*60 + min + ofs[z], reduced into 0..1439 by adding or subtracting 1440 at most once.
REQ-018 day_adj for the selected zone SHALL be -1 if the pre-reduction value is < 0, +1 if it is >= 1440, and 0 otherwise.
REQ-019 Mode 0 display: disp_bcd[31:16] = selected zone HHMM; disp_bcd[15:0] = zone 0 HHMM; all digits BCD.
REQ-020 Mode 1 display: disp_bcd[31:16] = selected zone HHMM; [15:8] = base sec as BCD; [7:0] = zone_sel as two BCD digits.
REQ-021 All outputs SHALL be registered; the effect of any input event is visible on outputs 2 clk cycles after the input edge: 1 cycle to state, 1 cycle to output register.

Reset
REQ-022 On reset asserted, asynchronously set: sec = min = hr = 0, all offsets = 0, zone_sel = 0, mode = 0, all edge-detect registers = 0.
REQ-023 On reset asserted, asynchronously set: disp_bcd = 32'h0000_0000, day_adj = 2'b00, day_wrap = 0.
REQ-024 Reset asserted mid-operation overrides all other inputs immediately; state resumes from reset values on the first clk edge after deassertion.
REQ-025 A button held high through reset deassertion SHALL NOT generate an edge.

Verification
REQ-026 Load 23:59 via set_en, then apply 60 ticks -> display 0000 on both halves in mode 0, day_wrap high for exactly 1 cycle.
REQ-027 Base 01:30; select zone 1 (one btn_zone edge); apply 2 btn_hr edges and 0 btn_qtr edges, then 6 btn_qtr edges (OFS_STEP_MIN = 15) -> disp_bcd[31:16] = 16'h0500, day_adj = 0.
REQ-028 Base 00:10; zone 1 offset driven to -720 (wrap reached from +840 with one btn_hr edge) -> disp_bcd[31:16] = 16'h1210, day_adj = 2'b11.
REQ-029 btn_hr and btn_qtr rise in the same cycle with offset 0 -> offset = +60; hold both high 10 cycles -> no further change.
REQ-030 set_en with set_hh = 24 while tick is high at base 05:00:00 -> base becomes 05:00:01; set_mm = 60 is likewise rejected.
REQ-031 Mode 1 with NUM_ZONES = 8: apply 7 btn_zone edges -> disp_bcd[7:0] = 8'h07; one more edge -> 8'h00; assert reset mid-test -> all outputs 0 in the same cycle.
